// File: rtl/fas_pkg.sv
// Shared types and helpers for the fas_acc accumulator: FSM state encoding,
// per-beat signed-overflow detection and the saturation constants.
package fas_pkg;

    typedef enum logic {ACCUM, HOLD} fas_acc_state_t;

    // Widest accumulator the saturation helper can describe.
    localparam int unsigned FAS_MAX_W = 64;
    localparam logic [FAS_MAX_W-1:0] FAS_ONE = {{(FAS_MAX_W-1){1'b0}}, 1'b1};

    function automatic logic fas_signed_ovf(input logic a_msb, input logic b_msb,
                                            input logic y_msb, input logic sel);
        logic operands_agree;
        operands_agree = sel ? (a_msb != b_msb) : (a_msb == b_msb);
        return operands_agree && (y_msb != a_msb);
    endfunction

    // Low n bits of the result are the n-bit signed max (positive) or min (negative).
    function automatic logic [FAS_MAX_W-1:0] fas_sat_value(input logic positive,
                                                           input int unsigned n);
        logic [FAS_MAX_W-1:0] low_ones;
        low_ones = (FAS_ONE << (n - 1)) - FAS_ONE;
        return positive ? low_ones : ~low_ones;
    endfunction

endpackage

// File: rtl/fasN.sv
// N-bit adder/subtractor: Y = A + B + CI (SEL=0) or A - B - CI (SEL=1), mod 2^N.
// CO is the raw carry out of the adder (for subtract, 1 means no borrow).
module fasN #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         SEL,
    input  logic         CI,
    output logic [N-1:0] Y,
    output logic         CO
);

    logic [N:0] sum;

    assign sum = {1'b0, A} + {1'b0, B ^ {N{SEL}}} + {{N{1'b0}}, SEL ^ CI};
    assign Y   = sum[N-1:0];
    assign CO  = sum[N];

endmodule

// File: rtl/fas_acc.sv
// Framed accumulator around fasN with a valid/ready result handshake.
// Optional macro FAS_ACC_SAT_EN clamps the accumulator on signed overflow.
module fas_acc
    import fas_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [N-1:0]     DIN,
    input  logic             SEL,
    input  logic             LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [N-1:0]     ACC,
    output logic             OVF,
    output logic             CO,
    output logic [CNT_W-1:0] COUNT
);

    fas_acc_state_t   state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             co_q, co_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0] fas_y;
    logic         fas_co;
    logic         ovf_beat;
    logic [N-1:0] acc_next;
    logic         in_ready;

    fasN #(.N(N)) u_fas (
        .A   (acc_q),
        .B   (DIN),
        .SEL (SEL),
        .CI  (1'b0),
        .Y   (fas_y),
        .CO  (fas_co)
    );

    assign ovf_beat = fas_signed_ovf(acc_q[N-1], DIN[N-1], fas_y[N-1], SEL);

`ifdef FAS_ACC_SAT_EN
    logic [FAS_MAX_W-1:0] sat_wide;

    // On overflow the true result always carries the sign of the accumulator.
    always_comb begin
        sat_wide = fas_sat_value(!acc_q[N-1], N);
        acc_next = ovf_beat ? sat_wide[N-1:0] : fas_y;
    end
`else
    assign acc_next = fas_y;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        co_d     = co_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = !CLR;
                if (CLR) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    co_d  = 1'b0;
                    cnt_d = '0;
                end else if (IN_VALID) begin
                    acc_d = acc_next;
                    ovf_d = ovf_q | ovf_beat;
                    co_d  = fas_co;
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (LAST) state_d = HOLD;
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    co_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = (state_q == HOLD);
    assign ACC       = acc_q;
    assign OVF       = ovf_q;
    assign CO        = co_q;
    assign COUNT     = cnt_q;

endmodule

// File: tb/tb_fas_acc.sv
// Self-checking bench for fas_acc (N=8, CNT_W=4): arithmetic reference model
// compared every cycle, plus directed literal expectations.
module tb_fas_acc;

    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = 4;

`ifdef FAS_ACC_SAT_EN
    localparam int EXP_POS_OVF = 'h7F;
    localparam int EXP_NEG_OVF = 'h80;
`else
    localparam int EXP_POS_OVF = 'h90;
    localparam int EXP_NEG_OVF = 'h7F;
`endif

    logic             CLK;
    logic             RST_N;
    logic             CLR;
    logic             IN_VALID;
    logic             IN_READY;
    logic [N-1:0]     DIN;
    logic             SEL;
    logic             LAST;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [N-1:0]     ACC;
    logic             OVF;
    logic             CO;
    logic [CNT_W-1:0] COUNT;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    fas_acc #(.N(N), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLR       (CLR),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .DIN       (DIN),
        .SEL       (SEL),
        .LAST      (LAST),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ACC       (ACC),
        .OVF       (OVF),
        .CO        (CO),
        .COUNT     (COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: signed integer arithmetic on the frame contents.
    int m_acc, m_cnt;
    bit m_ovf, m_co, m_hold;

    function automatic int s8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    always @(posedge CLK or negedge RST_N) begin : model
        int t, a;
        bit ov, c;
        if (!RST_N) begin
            m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_co <= 0; m_hold <= 0;
        end else if (m_hold) begin
            if (OUT_READY) begin
                m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_co <= 0; m_hold <= 0;
            end
        end else if (CLR) begin
            m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_co <= 0;
        end else if (IN_VALID) begin
            t  = SEL ? s8(m_acc) - s8(int'(DIN)) : s8(m_acc) + s8(int'(DIN));
            ov = (t > 127) || (t < -128);
            c  = SEL ? (m_acc >= int'(DIN)) : (m_acc + int'(DIN) > 255);
            a  = t & 255;
`ifdef FAS_ACC_SAT_EN
            if (ov) a = (t > 0) ? 127 : 128;
`endif
            m_acc <= a;
            m_ovf <= m_ovf | ov;
            m_co  <= c;
            m_cnt <= (m_cnt == 15) ? 15 : m_cnt + 1;
            if (LAST) m_hold <= 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_acc",       int'(ACC),       m_acc);
            chk("m_ovf",       int'(OVF),       int'(m_ovf));
            chk("m_co",        int'(CO),        int'(m_co));
            chk("m_count",     int'(COUNT),     m_cnt);
            chk("m_out_valid", int'(OUT_VALID), int'(m_hold));
            chk("m_in_ready",  int'(IN_READY),  int'(!m_hold && !CLR));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic l);
        IN_VALID = 1'b1; DIN = d; SEL = s; LAST = l;
        cyc();
        IN_VALID = 1'b0; LAST = 1'b0; SEL = 1'b0;
    endtask

    task automatic release_result();
        OUT_READY = 1'b1;
        cyc();
        OUT_READY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; CLR = 1'b0; IN_VALID = 1'b0; DIN = '0;
        SEL = 1'b0; LAST = 1'b0; OUT_READY = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_acc", int'(ACC), 0);
        chk("rst_out_valid", int'(OUT_VALID), 0);
        RST_N = 1'b1;
        cyc();

        // Partial frame then asynchronous reset mid-cycle.
        beat(8'h10, 1'b0, 1'b0);
        beat(8'h10, 1'b0, 1'b0);
        beat(8'h03, 1'b0, 1'b0);
        chk("pre_rst_acc", int'(ACC), 'h23);
        chk("pre_rst_count", int'(COUNT), 3);
        chk("model_pin_23", m_acc, 'h23);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_acc", int'(ACC), 0);
        chk("async_count", int'(COUNT), 0);
        chk("async_ovf", int'(OVF), 0);
        chk("async_out_valid", int'(OUT_VALID), 0);
        cyc();
        RST_N = 1'b1;

        // Mixed add/sub frame.
        beat(8'h10, 1'b0, 1'b0);
        beat(8'h05, 1'b0, 1'b0);
        beat(8'h03, 1'b1, 1'b1);
        chk("f1_out_valid", int'(OUT_VALID), 1);
        chk("f1_acc", int'(ACC), 'h12);
        chk("f1_count", int'(COUNT), 3);
        chk("f1_ovf", int'(OVF), 0);
        chk("model_pin_12", m_acc, 'h12);
        release_result();
        chk("f1_exit_acc", int'(ACC), 0);
        chk("f1_exit_in_ready", int'(IN_READY), 1);

        // Positive overflow frame, then stall the result with input pending.
        beat(8'h70, 1'b0, 1'b0);
        beat(8'h20, 1'b0, 1'b1);
        chk("f2_acc", int'(ACC), EXP_POS_OVF);
        chk("f2_ovf", int'(OVF), 1);
        chk("model_pin_f2", m_acc, EXP_POS_OVF);
        IN_VALID = 1'b1; DIN = 8'h55;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_acc", int'(ACC), EXP_POS_OVF);
            chk("hold_count", int'(COUNT), 2);
            chk("hold_in_ready", int'(IN_READY), 0);
            chk("hold_out_valid", int'(OUT_VALID), 1);
        end
        IN_VALID = 1'b0;
        release_result();
        chk("f2_exit_acc", int'(ACC), 0);
        chk("f2_exit_count", int'(COUNT), 0);
        chk("f2_exit_in_ready", int'(IN_READY), 1);

        // CLR wins over a pending beat, which is then taken next cycle.
        beat(8'h07, 1'b0, 1'b0);
        CLR = 1'b1; IN_VALID = 1'b1; DIN = 8'h44;
        #1;
        chk("clr_in_ready", int'(IN_READY), 0);
        cyc();
        chk("clr_acc", int'(ACC), 0);
        chk("clr_count", int'(COUNT), 0);
        CLR = 1'b0;
        cyc();
        chk("post_clr_acc", int'(ACC), 'h44);
        chk("post_clr_count", int'(COUNT), 1);
        IN_VALID = 1'b0;
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;

        // Beat counter saturation.
        for (int i = 0; i < 17; i++) beat(8'h01, 1'b0, (i == 16));
        for (int i = 0; i < 20 && !OUT_VALID; i++) cyc();
        chk("sat_out_valid", int'(OUT_VALID), 1);
        chk("sat_count", int'(COUNT), 'hF);
        chk("sat_acc", int'(ACC), 'h11);
        release_result();

        // Negative overflow via subtract.
        beat(8'h80, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 1'b1);
        chk("neg_acc", int'(ACC), EXP_NEG_OVF);
        chk("neg_ovf", int'(OVF), 1);
        chk("neg_co", int'(CO), 1);
        release_result();

        // Borrow wrap without signed overflow.
        beat(8'h01, 1'b1, 1'b1);
        chk("borrow_acc", int'(ACC), 'hFF);
        chk("borrow_ovf", int'(OVF), 0);
        chk("borrow_co", int'(CO), 0);
        release_result();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
